// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both ends of the bus: target FSM states and
// the bus-level meanings of the ACK and R/W bits.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_slave_state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the iClk domain and derives edge and START/STOP events
// from the synchronised value and a one-cycle-delayed copy of each line.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iClk,
  input  logic iRst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_dly_q, scl_dly_d;
  logic                   sda_dly_q, sda_dly_d;
  logic                   scl_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_dly_d  = scl_s;
    sda_dly_d  = sda_s;
  end

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_dly_d;
      sda_dly_q  <= sda_dly_d;
    end
  end

  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  // SCL must be high on both samples so an SDA move at an SCL edge is not a bus condition.
  assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address: receives write bytes, returns read
// bytes from the user side, open-drain SDA, never drives SCL.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       iClk,
  input  logic       iRst,
  inout  wire        ioSCL,
  inout  wire        ioSDA,
  input  logic [7:0] iTx_Data,
  output logic       oTx_Req,
  output logic [7:0] oRx_Data,
  output logic       oRx_Valid,
  output logic       oAddressed,
  output logic       oRw,
  output logic       oStop
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .iClk      (iClk),
    .iRst      (iRst),
    .scl_in    (ioSCL),
    .sda_in    (ioSDA),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_slave_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [6:0] tx_sr_q, tx_sr_d;   // MSB goes straight to SDA at load; the rest waits here
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       addressed_q, addressed_d;
  logic       rw_q, rw_d;
  logic       stop_q, stop_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    stop_d      = 1'b0;

    if (start_det) begin
      state_d     = ST_ADDR;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      addressed_d = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      sda_oe_d    = 1'b0;
      byte_done_d = 1'b0;
      addressed_d = 1'b0;
      stop_d      = addressed_q;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_RX: begin
          if (scl_rise) begin
            rx_sr_d   = {rx_sr_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (state_q == ST_RX) begin
              rx_data_d  = rx_sr_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = ST_RX_ACK;
            end else if (rx_sr_q[7:1] == SLAVE_ADDR) begin
              sda_oe_d = 1'b1;
              rw_d     = rx_sr_q[0];
              tx_req_d = (rx_sr_q[0] == I2C_RW_READ);
              state_d  = ST_ADDR_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            addressed_d = 1'b1;
            bit_cnt_d   = 3'd0;
            if (rw_q == I2C_RW_READ) begin
              tx_sr_d  = iTx_Data[6:0];
              sda_oe_d = ~iTx_Data[7];
              state_d  = ST_TX;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_RX;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = ST_RX;
          end
        end
        // bit_cnt counts SCL falls here: the 8th fall ends the last data bit.
        ST_TX: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              sda_oe_d  = 1'b0;
              state_d   = ST_TX_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              sda_oe_d  = ~tx_sr_q[6];
              tx_sr_d   = {tx_sr_q[5:0], 1'b0};
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              tx_req_d    = 1'b1;
              byte_done_d = 1'b1;
            end else begin
              addressed_d = 1'b0;
              state_d     = ST_WAIT_STOP;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            tx_sr_d     = iTx_Data[6:0];
            sda_oe_d    = ~iTx_Data[7];
            state_d     = ST_TX;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      rx_sr_q     <= 8'd0;
      tx_sr_q     <= 7'd0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      stop_q      <= stop_d;
    end
  end

  assign ioSCL      = 1'bz;
  assign ioSDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign oTx_Req    = tx_req_q;
  assign oRx_Data   = rx_data_q;
  assign oRx_Valid  = rx_valid_q;
  assign oAddressed = addressed_q;
  assign oRw        = rw_q;
  assign oStop      = stop_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: a bit-banged open-drain master exercises the I2C target and
// checks ACKs, returned bytes and user-side pulses against hand-computed values.
module tb_i2c_slave;

  localparam int Q = 20;  // quarter SCL period in iClk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       m_scl_low;
  logic       m_sda_low;
  wire        scl_bus;
  wire        sda_bus;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addressed;
  logic       rw;
  logic       stop_p;

  assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (scl_bus);
  pullup (sda_bus);

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .iClk       (clk),
    .iRst       (rst),
    .ioSCL      (scl_bus),
    .ioSDA      (sda_bus),
    .iTx_Data   (tx_data),
    .oTx_Req    (tx_req),
    .oRx_Data   (rx_data),
    .oRx_Valid  (rx_valid),
    .oAddressed (addressed),
    .oRw        (rw),
    .oStop      (stop_p)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Pulse monitors; tests only take before/after snapshots of these.
  int         rx_cnt = 0;
  int         txreq_cnt = 0;
  int         stop_cnt = 0;
  int         slave_low_cnt = 0;
  logic [7:0] rx_hist [0:63];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_hist[rx_cnt[5:0]] = rx_data;
      rx_cnt++;
    end
    if (tx_req) txreq_cnt++;
    if (stop_p) stop_cnt++;
    if (!m_sda_low && sda_bus === 1'b0) slave_low_cnt++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // Works from idle (SCL high) and as a repeated START (SCL low).
  task automatic bus_start();
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda_low = ~b; wait_q();
    m_scl_low = 1'b0; wait_q();
    s = sda_bus;    wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, ack);
    $display("write 0x%02h ack=%0b", d, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(ack, s);
    $display("read 0x%02h master_ack=%0b", d, ack);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_scl_low = 1'b0; m_sda_low = 1'b0; tx_data = 8'h00;
    repeat (5) @(negedge clk);
    vec_cnt++;
    if ({tx_req, rx_data, rx_valid, addressed, rw, stop_p} !== 13'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b required 0", {tx_req, rx_data, rx_valid, addressed, rw, stop_p});
    end
    vec_cnt++;
    if (sda_bus !== 1'b1) begin
      err_cnt++; $display("FAIL reset_sda: got %b required 1", sda_bus);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_write();
    logic ack0, ack1, ack2;
    int rx0, st0;
    rx0 = rx_cnt; st0 = stop_cnt;
    bus_start();
    write_byte(8'hA0, ack0);
    write_byte(8'hA5, ack1);
    write_byte(8'h3C, ack2);
    vec_cnt++;
    if ({ack0, ack1, ack2} !== 3'b000) begin
      err_cnt++; $display("FAIL write_acks: got %b required 000", {ack0, ack1, ack2});
    end
    vec_cnt++;
    if (addressed !== 1'b1) begin
      err_cnt++; $display("FAIL write_addressed: got %b required 1", addressed);
    end
    bus_stop();
    vec_cnt++;
    if (rx_cnt - rx0 != 2) begin
      err_cnt++; $display("FAIL write_rx_valid_count: got %0d required 2", rx_cnt - rx0);
    end
    vec_cnt++;
    if (rx_hist[rx0[5:0]] !== 8'hA5 || rx_hist[6'(rx0 + 1)] !== 8'h3C) begin
      err_cnt++;
      $display("FAIL write_rx_bytes: got %02h %02h required a5 3c", rx_hist[rx0[5:0]], rx_hist[6'(rx0 + 1)]);
    end
    vec_cnt++;
    if (stop_cnt - st0 != 1) begin
      err_cnt++; $display("FAIL write_stop_count: got %0d required 1", stop_cnt - st0);
    end
    vec_cnt++;
    if ({addressed, rw, rx_data} !== {2'b00, 8'h3C}) begin
      err_cnt++; $display("FAIL write_after_stop: got %b %b %02h required 0 0 3c", addressed, rw, rx_data);
    end
  endtask

  task automatic test_wrong_addr();
    logic ack0, ack1;
    int rx0, tr0, sl0;
    rx0 = rx_cnt; tr0 = txreq_cnt; sl0 = slave_low_cnt;
    bus_start();
    write_byte(8'hA2, ack0);
    write_byte(8'hA0, ack1);  // no START first: target must be back in IDLE
    vec_cnt++;
    if ({ack0, ack1} !== 2'b11) begin
      err_cnt++; $display("FAIL wrong_addr_nack: got %b required 11", {ack0, ack1});
    end
    vec_cnt++;
    if (rx_cnt != rx0 || txreq_cnt != tr0 || slave_low_cnt != sl0) begin
      err_cnt++;
      $display("FAIL wrong_addr_quiet: rx %0d txreq %0d sda_low %0d required 0 0 0", rx_cnt - rx0, txreq_cnt - tr0, slave_low_cnt - sl0);
    end
    bus_stop();
  endtask

  task automatic test_read();
    logic ack0;
    logic [7:0] d0, d1;
    int tr0, st0;
    tr0 = txreq_cnt; st0 = stop_cnt;
    tx_data = 8'hC3;
    bus_start();
    write_byte(8'hA1, ack0);
    tx_data = 8'h5A;
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b1);
    vec_cnt++;
    if (ack0 !== 1'b0 || d0 !== 8'hC3 || d1 !== 8'h5A) begin
      err_cnt++; $display("FAIL read_data: ack %b bytes %02h %02h required 0 c3 5a", ack0, d0, d1);
    end
    vec_cnt++;
    if (txreq_cnt - tr0 != 2) begin
      err_cnt++; $display("FAIL read_tx_req_count: got %0d required 2", txreq_cnt - tr0);
    end
    wait_q();
    vec_cnt++;
    if (sda_bus !== 1'b1 || addressed !== 1'b0 || rw !== 1'b1) begin
      err_cnt++; $display("FAIL read_after_nack: sda %b addressed %b rw %b required 1 0 1", sda_bus, addressed, rw);
    end
    bus_stop();
    vec_cnt++;
    if (stop_cnt != st0) begin
      err_cnt++; $display("FAIL read_stop_after_nack: got %0d pulses required 0", stop_cnt - st0);
    end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    logic [7:0] d;
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'h01, a1);
    vec_cnt++;
    if ({a0, a1} !== 2'b00 || rx_data !== 8'h01 || rw !== 1'b0 || addressed !== 1'b1) begin
      err_cnt++;
      $display("FAIL b2b_write_phase: acks %b rx %02h rw %b addressed %b required 00 01 0 1", {a0, a1}, rx_data, rw, addressed);
    end
    tx_data = 8'h96;
    bus_start();
    write_byte(8'hA1, a2);
    vec_cnt++;
    if (a2 !== 1'b0 || rw !== 1'b1 || addressed !== 1'b1) begin
      err_cnt++; $display("FAIL b2b_restart: ack %b rw %b addressed %b required 0 1 1", a2, rw, addressed);
    end
    read_byte(d, 1'b1);
    vec_cnt++;
    if (d !== 8'h96 || addressed !== 1'b0 || rx_data !== 8'h01) begin
      err_cnt++; $display("FAIL b2b_read: byte %02h addressed %b rx %02h required 96 0 01", d, addressed, rx_data);
    end
    bus_stop();
  endtask

  task automatic test_async_reset();
    logic a0, a1;
    tx_data = 8'h00;
    bus_start();
    write_byte(8'hA1, a0);
    vec_cnt++;
    if (a0 !== 1'b0 || sda_bus !== 1'b0) begin
      err_cnt++; $display("FAIL rst_pre_driving: ack %b sda %b required 0 0", a0, sda_bus);
    end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if (sda_bus !== 1'b1 || addressed !== 1'b0) begin
      err_cnt++; $display("FAIL rst_async_release: sda %b addressed %b required 1 0", sda_bus, addressed);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("mid-transfer reset applied");
    bus_start();
    write_byte(8'hA0, a1);
    vec_cnt++;
    if (a1 !== 1'b0 || addressed !== 1'b1) begin
      err_cnt++; $display("FAIL rst_recover_ack: ack %b addressed %b required 0 1", a1, addressed);
    end
    bus_stop();
  endtask

  task automatic test_glitch();
    logic s, a0;
    int sl0;
    sl0 = slave_low_cnt;
    bus_start();
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    bus_stop();
    write_byte(8'hA0, a0);
    vec_cnt++;
    if (a0 !== 1'b1 || slave_low_cnt != sl0 || addressed !== 1'b0) begin
      err_cnt++;
      $display("FAIL glitch_no_ack: ack %b sda_low %0d addressed %b required 1 0 0", a0, slave_low_cnt - sl0, addressed);
    end
    bus_stop();
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_back_to_back();
    test_async_reset();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
